// File: rtl/mdu_pkg.sv
// Shared definitions for the iterative multiply/divide unit: op codes and FSM states.
package mdu_pkg;

  localparam int MDU_WIDTH      = 32;
  localparam int MDU_REG_ADDR_W = 5;

  typedef enum logic [1:0] {
    MDU_MUL   = 2'b00,
    MDU_MULHU = 2'b01,
    MDU_DIVU  = 2'b10,
    MDU_REMU  = 2'b11
  } mdu_op_t;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } mdu_state_t;

  // Both divide op codes have the upper bit set.
  function automatic logic mdu_is_div(mdu_op_t op);
    return op[1];
  endfunction

endpackage

// File: rtl/mul_div_unit_if.sv
// Issue and writeback bundle between the execute stage and the multiply/divide unit.
interface mul_div_unit_if
  import mdu_pkg::*;
#(
  parameter int WIDTH      = MDU_WIDTH,
  parameter int REG_ADDR_W = MDU_REG_ADDR_W
);
  logic                  start;
  mdu_op_t               op;
  logic [REG_ADDR_W-1:0] dest;
  logic [WIDTH-1:0]      src_a;
  logic [WIDTH-1:0]      src_b;
  logic                  flush;
  logic                  busy;
  logic                  wb_en;
  logic [REG_ADDR_W-1:0] wb_reg;
  logic [WIDTH-1:0]      wb_data;

  modport master (
    output start, op, dest, src_a, src_b, flush,
    input  busy, wb_en, wb_reg, wb_data
  );

  modport slave (
    input  start, op, dest, src_a, src_b, flush,
    output busy, wb_en, wb_reg, wb_data
  );
endinterface

// File: rtl/mdu_step.sv
// One radix-2 iteration: shift-add multiply step or restoring trial-subtract divide step.
module mdu_step #(
  parameter int WIDTH = 32
) (
  input  logic             is_div,
  input  logic [WIDTH-1:0] acc,      // product high half / partial remainder
  input  logic [WIDTH-1:0] q,        // multiplier bits / dividend-quotient bits
  input  logic [WIDTH-1:0] d,        // multiplicand / divisor
  output logic [WIDTH-1:0] acc_next,
  output logic [WIDTH-1:0] q_next
);

  logic [WIDTH:0]   sum;
  logic [WIDTH:0]   shifted;
  logic [WIDTH+1:0] diff;
  logic             fits;

  always_comb begin
    sum      = {1'b0, acc} + (q[0] ? {1'b0, d} : '0);
    shifted  = {acc, q[WIDTH-1]};
    diff     = {1'b0, shifted} - {2'b00, d};
    fits     = ~diff[WIDTH+1];
    acc_next = '0;
    q_next   = '0;
    if (is_div) begin
      // The remainder always stays below the divisor, so WIDTH bits hold it after restore.
      acc_next = fits ? diff[WIDTH-1:0] : shifted[WIDTH-1:0];
      q_next   = {q[WIDTH-2:0], fits};
    end else begin
      acc_next = sum[WIDTH:1];
      q_next   = {sum[0], q[WIDTH-1:1]};
    end
  end

endmodule

// File: rtl/mul_div_unit.sv
// Iterative unsigned multiply/divide unit: one bit per clock, one-cycle writeback strobe.
module mul_div_unit
  import mdu_pkg::*;
#(
  parameter int WIDTH      = MDU_WIDTH,
  parameter int REG_ADDR_W = MDU_REG_ADDR_W
) (
  input  logic           clk,
  input  logic           rst,
  mul_div_unit_if.slave  bus
);

  localparam int CNT_W = $clog2(WIDTH);

  mdu_state_t            state_reg;
  mdu_op_t               op_reg;
  logic [REG_ADDR_W-1:0] dest_reg;
  logic [WIDTH-1:0]      d_reg;
  logic [WIDTH-1:0]      acc_reg;
  logic [WIDTH-1:0]      q_reg;
  logic [CNT_W-1:0]      count_reg;
  logic                  busy_reg;
  logic                  wb_en_reg;
  logic [REG_ADDR_W-1:0] wb_reg_reg;
  logic [WIDTH-1:0]      wb_data_reg;

  logic [WIDTH-1:0]      acc_next;
  logic [WIDTH-1:0]      q_next;
  logic [WIDTH-1:0]      result_next;

  mdu_step #(.WIDTH(WIDTH)) u_step (
    .is_div   (mdu_is_div(op_reg)),
    .acc      (acc_reg),
    .q        (q_reg),
    .d        (d_reg),
    .acc_next (acc_next),
    .q_next   (q_next)
  );

  // The final iteration's outputs are the result, so it is captured on the last RUN edge.
  always_comb begin
    result_next = q_next;
    case (op_reg)
      MDU_MUL, MDU_DIVU:   result_next = q_next;
      MDU_MULHU, MDU_REMU: result_next = acc_next;
      default:             result_next = q_next;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_reg   <= IDLE;
      op_reg      <= MDU_MUL;
      dest_reg    <= '0;
      d_reg       <= '0;
      acc_reg     <= '0;
      q_reg       <= '0;
      count_reg   <= '0;
      busy_reg    <= 1'b0;
      wb_en_reg   <= 1'b0;
      wb_reg_reg  <= '0;
      wb_data_reg <= '0;
    end else begin
      case (state_reg)
        IDLE: begin
          wb_en_reg <= 1'b0;
          if (bus.start && !bus.flush) begin
            op_reg    <= bus.op;
            dest_reg  <= bus.dest;
            // Multiply walks the multiplier through q; divide shifts the dividend out of q.
            d_reg     <= mdu_is_div(bus.op) ? bus.src_b : bus.src_a;
            q_reg     <= mdu_is_div(bus.op) ? bus.src_a : bus.src_b;
            acc_reg   <= '0;
            count_reg <= '0;
            state_reg <= RUN;
            busy_reg  <= 1'b1;
          end
        end
        RUN: begin
          if (bus.flush) begin
            state_reg <= IDLE;
            busy_reg  <= 1'b0;
            wb_en_reg <= 1'b0;
          end else begin
            acc_reg   <= acc_next;
            q_reg     <= q_next;
            count_reg <= count_reg + CNT_W'(1);
            if (count_reg == CNT_W'(WIDTH - 1)) begin
              state_reg   <= DONE;
              wb_en_reg   <= 1'b1;
              wb_reg_reg  <= dest_reg;
              wb_data_reg <= result_next;
            end
          end
        end
        DONE: begin
          state_reg <= IDLE;
          busy_reg  <= 1'b0;
          wb_en_reg <= 1'b0;
        end
        default: begin
          state_reg <= IDLE;
          busy_reg  <= 1'b0;
          wb_en_reg <= 1'b0;
        end
      endcase
    end
  end

  // Flush or reset arriving during DONE must still suppress the strobe in that same cycle.
  assign bus.wb_en   = wb_en_reg & ~bus.flush & ~rst;
  assign bus.busy    = busy_reg;
  assign bus.wb_reg  = wb_reg_reg;
  assign bus.wb_data = wb_data_reg;

endmodule

// File: tb/tb_mul_div_unit.sv
// Scoreboard bench for mul_div_unit: directed ops, ignored starts, reset and flush aborts.
module tb_mul_div_unit;
  import mdu_pkg::*;

  localparam int W  = 32;
  localparam int RW = 5;

  logic clk = 1'b0;
  logic rst = 1'b1;
  int   cyc = 0;

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  mul_div_unit_if #(.WIDTH(W), .REG_ADDR_W(RW)) bus ();

  mul_div_unit #(.WIDTH(W), .REG_ADDR_W(RW)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  typedef struct {
    logic [RW-1:0] dest;
    logic [W-1:0]  data;
    int            acc_cyc;
  } exp_t;

  exp_t sb[$];
  int   checks = 0;
  int   errors = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s actual=%0h required=%0h", name, act, req);
    end
  endtask

  // Monitor: every strobe must match the head of the scoreboard, 33 cycles after the start cycle.
  initial begin
    exp_t e;
    forever begin
      @(negedge clk);
      if (bus.wb_en === 1'b1) begin
        if (sb.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL unexpected_wb actual reg=%0d data=%0h required=no write", bus.wb_reg, bus.wb_data);
        end else begin
          e = sb.pop_front();
          check("wb_reg", 64'(bus.wb_reg), 64'(e.dest));
          check("wb_data", 64'(bus.wb_data), 64'(e.data));
          check("wb_latency", 64'(cyc - e.acc_cyc), 64'd33);
          $display("WB reg=%0d data=%0h latency=%0d", bus.wb_reg, bus.wb_data, cyc - e.acc_cyc);
          @(negedge clk);
          check("wb_en_one_cycle", 64'(bus.wb_en), 64'd0);
          check("busy_after_wb", 64'(bus.busy), 64'd0);
        end
      end
    end
  end

  // Start is driven in cycle c0 and sampled on the following edge.
  task automatic issue(input mdu_op_t op, input logic [W-1:0] a, input logic [W-1:0] b,
                       input logic [RW-1:0] d, output int c0);
    int n;
    n = 0;
    @(negedge clk);
    while (bus.busy !== 1'b0 && n < 100) begin
      @(negedge clk);
      n++;
    end
    if (n >= 100) begin
      checks++;
      errors++;
      $display("FAIL issue_timeout actual busy=%0b required=0", bus.busy);
    end
    bus.start = 1'b1;
    bus.op    = op;
    bus.dest  = d;
    bus.src_a = a;
    bus.src_b = b;
    c0        = cyc;
    @(negedge clk);
    bus.start = 1'b0;
    check("busy_after_accept", 64'(bus.busy), 64'd1);
  endtask

  task automatic wait_idle();
    int n;
    n = 0;
    while (bus.busy !== 1'b0 && n < 100) begin
      @(negedge clk);
      n++;
    end
    if (n >= 100) begin
      checks++;
      errors++;
      $display("FAIL idle_timeout actual busy=%0b required=0", bus.busy);
    end
  endtask

  task automatic run_op(input mdu_op_t op, input logic [W-1:0] a, input logic [W-1:0] b,
                        input logic [RW-1:0] d, input logic [W-1:0] expv);
    int c0;
    issue(op, a, b, d, c0);
    sb.push_back('{dest: d, data: expv, acc_cyc: c0});
    $display("ISSUE op=%0d a=%0h b=%0h dest=%0d expect=%0h", op, a, b, d, expv);
    wait_idle();
    @(negedge clk);
  endtask

  initial begin
    int c0;
    bus.start = 1'b0;
    bus.op    = MDU_MUL;
    bus.dest  = '0;
    bus.src_a = '0;
    bus.src_b = '0;
    bus.flush = 1'b0;
    rst       = 1'b1;
    repeat (3) @(negedge clk);
    rst = 1'b0;
    repeat (5) @(negedge clk);
    check("reset_busy", 64'(bus.busy), 64'd0);
    check("reset_wb_en", 64'(bus.wb_en), 64'd0);
    check("reset_wb_reg", 64'(bus.wb_reg), 64'd0);
    check("reset_wb_data", 64'(bus.wb_data), 64'd0);

    run_op(MDU_MUL,   32'd7,        32'd6,        5'd3,  32'd42);
    run_op(MDU_MULHU, 32'hFFFFFFFF, 32'hFFFFFFFF, 5'd10, 32'hFFFFFFFE);
    run_op(MDU_MUL,   32'hFFFFFFFF, 32'hFFFFFFFF, 5'd11, 32'h00000001);
    run_op(MDU_DIVU,  32'd100,      32'd7,        5'd12, 32'd14);
    run_op(MDU_REMU,  32'd100,      32'd7,        5'd13, 32'd2);
    run_op(MDU_DIVU,  32'd5,        32'd0,        5'd14, 32'hFFFFFFFF);
    run_op(MDU_REMU,  32'd5,        32'd0,        5'd15, 32'd5);
    run_op(MDU_MUL,   32'h00010000, 32'h00030000, 5'd0,  32'h00000000);
    run_op(MDU_MULHU, 32'h00010000, 32'h00030000, 5'd31, 32'h00000003);

    // Starts during RUN, plus operand changes, must be ignored.
    issue(MDU_MUL, 32'd9, 32'd11, 5'd7, c0);
    sb.push_back('{dest: 5'd7, data: 32'd99, acc_cyc: c0});
    $display("ISSUE op=%0d a=9 b=11 dest=7 expect=63 with starts at +10/+20", MDU_MUL);
    for (int k = 0; k < 40; k++) begin
      bus.start = ((cyc - c0) == 10) || ((cyc - c0) == 20);
      bus.op    = MDU_DIVU;
      bus.dest  = 5'd20;
      bus.src_a = 32'd1000;
      bus.src_b = 32'd3;
      @(negedge clk);
    end
    bus.start = 1'b0;
    check("ignored_start_sb_empty", 64'(sb.size()), 64'd0);
    run_op(MDU_DIVU, 32'd1000, 32'd3, 5'd20, 32'd333);

    // Reset at iteration 16 aborts with no writeback.
    issue(MDU_DIVU, 32'd100, 32'd7, 5'd4, c0);
    repeat (15) @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    check("rst_abort_busy", 64'(bus.busy), 64'd0);
    check("rst_abort_wb_en", 64'(bus.wb_en), 64'd0);
    check("rst_abort_wb_data", 64'(bus.wb_data), 64'd0);
    $display("RST_ABORT busy=%0b wb_data=%0h", bus.busy, bus.wb_data);
    repeat (40) @(negedge clk);

    // Flush at iteration 16 aborts and leaves the previous writeback values in place.
    run_op(MDU_MUL, 32'd5, 32'd5, 5'd6, 32'd25);
    issue(MDU_MULHU, 32'hFFFFFFFF, 32'h12345678, 5'd8, c0);
    repeat (15) @(negedge clk);
    bus.flush = 1'b1;
    @(negedge clk);
    bus.flush = 1'b0;
    check("flush_busy", 64'(bus.busy), 64'd0);
    check("flush_wb_data_kept", 64'(bus.wb_data), 64'd25);
    check("flush_wb_reg_kept", 64'(bus.wb_reg), 64'd6);
    $display("FLUSH_ABORT busy=%0b wb_reg=%0d wb_data=%0h", bus.busy, bus.wb_reg, bus.wb_data);
    repeat (40) @(negedge clk);

    // Flush together with start in IDLE: no accept.
    bus.start = 1'b1;
    bus.flush = 1'b1;
    @(negedge clk);
    bus.start = 1'b0;
    bus.flush = 1'b0;
    check("flush_blocks_start", 64'(bus.busy), 64'd0);
    repeat (40) @(negedge clk);

    check("sb_drained", 64'(sb.size()), 64'd0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL global_timeout actual=running required=finished");
    $fatal(1, "timeout");
  end

endmodule
